// File: rtl/store_drain_buffer.sv
// store_drain_buffer
// Consumer end of the MEM/WB store interface. Committed stores are captured
// into a small circular FIFO and drained to the data-memory write port over a
// valid/ready handshake. A load-address lookup over the pending entries keeps
// younger loads from reading stale memory.
//
// Configuration macro: STB_LOAD_FWD_EN
//   defined   - full-doubleword matches are forwarded (ld_hit_o/ld_data_o),
//               partial-strobe matches stall the load.
//   undefined - no forwarding; any match stalls the load.
//
// Ports:
//   clk_i, rst_ni             clock (rising edge), async active-low reset
//   ememw_i, memaddr_i,
//   wbmem_i, wstrb_i          store request, address, aligned data, lane enables
//   full_o, empty_o, count_o  occupancy status (combinational from count)
//   ovf_o                     sticky: a store arrived while full (dropped)
//   mem_w*                    head-entry write request to data memory
//   ld_addr_i                 load address to check
//   ld_hit_o, ld_data_o       forwarded load data (valid when ld_hit_o)
//   ld_stall_o                load must wait for the buffer to drain
module store_drain_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ememw_i,
  input  logic [DATA_WIDTH-1:0] memaddr_i,
  input  logic [DATA_WIDTH-1:0] wbmem_i,
  input  logic [7:0]            wstrb_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [PTR_W:0]        count_o,
  output logic                  ovf_o,
  output logic                  mem_wvalid_o,
  input  logic                  mem_wready_i,
  output logic [DATA_WIDTH-1:0] mem_waddr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [7:0]            mem_wstrb_o,
  input  logic [DATA_WIDTH-1:0] ld_addr_i,
  output logic                  ld_hit_o,
  output logic [DATA_WIDTH-1:0] ld_data_o,
  output logic                  ld_stall_o
);

  // Only the doubleword address is kept; the byte offset is carried by strobes.
  localparam int AW = DATA_WIDTH - 3;

  logic [AW-1:0]         addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [7:0]            strb_q [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             ovf;

  logic push;
  logic pop;

  logic                  hit_any;
  logic                  hit_full;
  logic [DATA_WIDTH-1:0] hit_data;
  logic [PTR_W-1:0]      idx;

  logic unused_low_bits;
  assign unused_low_bits = ^{memaddr_i[2:0], ld_addr_i[2:0]};

  assign full_o       = (count == (PTR_W+1)'(DEPTH));
  assign empty_o      = (count == {(PTR_W+1){1'b0}});
  assign count_o      = count;
  assign ovf_o        = ovf;
  assign mem_wvalid_o = !empty_o;
  assign mem_waddr_o  = {addr_q[head], 3'b000};
  assign mem_wdata_o  = data_q[head];
  assign mem_wstrb_o  = strb_q[head];

  // Full is judged on the pre-edge count, so a same-cycle pop never admits a push.
  assign push = ememw_i && !full_o;
  assign pop  = mem_wvalid_o && mem_wready_i;

  // Pointer, occupancy and sticky-overflow state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head  <= {PTR_W{1'b0}};
      tail  <= {PTR_W{1'b0}};
      count <= {(PTR_W+1){1'b0}};
      ovf   <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        head <= head + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   count <= count + {{PTR_W{1'b0}}, 1'b1};
        2'b01:   count <= count - {{PTR_W{1'b0}}, 1'b1};
        default: count <= count;
      endcase
      if (ememw_i && full_o) begin
        ovf <= 1'b1;
      end
    end
  end

  // Entry storage; contents are qualified by count, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[tail] <= memaddr_i[DATA_WIDTH-1:3];
      data_q[tail] <= wbmem_i;
      strb_q[tail] <= wstrb_i;
    end
  end

  // Load lookup: walk oldest to youngest so the youngest match wins.
  always_comb begin
    hit_any  = 1'b0;
    hit_full = 1'b0;
    hit_data = {DATA_WIDTH{1'b0}};
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && (addr_q[idx] == ld_addr_i[DATA_WIDTH-1:3])) begin
        hit_any  = 1'b1;
        hit_full = (strb_q[idx] == 8'hFF);
        hit_data = data_q[idx];
      end else begin
        hit_any = hit_any;
      end
    end
  end

`ifdef STB_LOAD_FWD_EN
  assign ld_hit_o   = hit_any && hit_full;
  assign ld_data_o  = ld_hit_o ? hit_data : {DATA_WIDTH{1'b0}};
  assign ld_stall_o = hit_any && !hit_full;
`else
  logic unused_fwd;
  assign unused_fwd = ^{hit_full, hit_data};
  assign ld_hit_o   = 1'b0;
  assign ld_data_o  = {DATA_WIDTH{1'b0}};
  assign ld_stall_o = hit_any;
`endif

endmodule

// File: tb/tb_store_drain_buffer.sv
module tb_store_drain_buffer;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        ememw;
  logic [63:0] memaddr;
  logic [63:0] wbmem;
  logic [7:0]  wstrb;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        ovf;
  logic        wvalid;
  logic        wready;
  logic [63:0] waddr;
  logic [63:0] wdata;
  logic [7:0]  wstrb_out;
  logic [63:0] ld_addr;
  logic        ld_hit;
  logic [63:0] ld_data;
  logic        ld_stall;

  int   errors = 0;
  int   checks = 0;
  ent_t exp_q[$];
  int   mcount = 0;
  logic movf   = 1'b0;

  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [63:0] prev_a;
  logic [63:0] prev_d;
  logic [7:0]  prev_s;

  store_drain_buffer #(.DATA_WIDTH(64), .DEPTH(4), .PTR_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ememw_i(ememw), .memaddr_i(memaddr),
    .wbmem_i(wbmem), .wstrb_i(wstrb), .full_o(full), .empty_o(empty),
    .count_o(count), .ovf_o(ovf), .mem_wvalid_o(wvalid), .mem_wready_i(wready),
    .mem_waddr_o(waddr), .mem_wdata_o(wdata), .mem_wstrb_o(wstrb_out),
    .ld_addr_i(ld_addr), .ld_hit_o(ld_hit), .ld_data_o(ld_data), .ld_stall_o(ld_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_v && !prev_r && wvalid) begin
        chk("hold_addr", waddr, prev_a);
        chk("hold_data", wdata, prev_d);
        chk("hold_strb", {56'd0, wstrb_out}, {56'd0, prev_s});
      end
      if (wvalid && wready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("wr_addr", waddr, e.addr);
          chk("wr_data", wdata, e.data);
          chk("wr_strb", {56'd0, wstrb_out}, {56'd0, e.strb});
        end
      end
    end
    prev_v = wvalid && rst_n;
    prev_r = wready;
    prev_a = waddr;
    prev_d = wdata;
    prev_s = wstrb_out;
  end

  // One clock edge with the given inputs; updates the bench model.
  task automatic step(input logic we, input logic [63:0] a, input logic [63:0] d,
                      input logic [7:0] s, input logic rdy);
    int push_ok;
    int pop_ok;
    ememw   = we;
    memaddr = a;
    wbmem   = d;
    wstrb   = s;
    wready  = rdy;
    push_ok = (we && mcount < 4) ? 1 : 0;
    pop_ok  = (mcount != 0 && rdy) ? 1 : 0;
    if (we && mcount == 4) movf = 1'b1;
    if (push_ok == 1) exp_q.push_back('{addr: a & ~64'h7, data: d, strb: s});
    mcount = mcount + push_ok - pop_ok;
    @(posedge clk);
    #2;
    ememw  = 1'b0;
    wready = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, {61'd0, count}, 64'(mcount));
    chk({tag, "_full"},  {63'd0, full},  {63'd0, (mcount == 4)});
    chk({tag, "_empty"}, {63'd0, empty}, {63'd0, (mcount == 0)});
    chk({tag, "_valid"}, {63'd0, wvalid}, {63'd0, (mcount != 0)});
    chk({tag, "_ovf"},   {63'd0, ovf},   {63'd0, movf});
  endtask

  task automatic chk_ld(input string tag, input logic h, input logic [63:0] d, input logic st);
    #1;
    chk({tag, "_hit"},   {63'd0, ld_hit},   {63'd0, h});
    chk({tag, "_data"},  ld_data, d);
    chk({tag, "_stall"}, {63'd0, ld_stall}, {63'd0, st});
  endtask

  initial begin
    rst_n   = 1'b0;
    ememw   = 1'b0;
    memaddr = 64'd0;
    wbmem   = 64'd0;
    wstrb   = 8'd0;
    wready  = 1'b0;
    ld_addr = 64'hFFFF_0000;
    #1;
    chk_status("reset");
    chk("reset_hit", {63'd0, ld_hit}, 64'd0);
    chk("reset_stall", {63'd0, ld_stall}, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Single store held by ready=0 for three cycles, then drained.
    step(1'b1, 64'h1000, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b0);
    chk_status("single_push");
    chk("single_addr", waddr, 64'h1000);
    chk("single_data", wdata, 64'hDEADBEEF_CAFEF00D);
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 64'd0, 8'd0, 1'b0);
    chk_status("single_hold");
    step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    chk_status("single_drain");

    // Fill to DEPTH, overflow once, then drain in FIFO order.
    step(1'b1, 64'h0100, 64'h1111_0000_0000_0001, 8'hFF, 1'b0);
    step(1'b1, 64'h0208, 64'h2222_0000_0000_0002, 8'h0F, 1'b0);
    step(1'b1, 64'h0310, 64'h3333_0000_0000_0003, 8'hF0, 1'b0);
    step(1'b1, 64'h041F, 64'h4444_0000_0000_0004, 8'h80, 1'b0);
    chk_status("fill");
    step(1'b1, 64'h0500, 64'h5555_0000_0000_0005, 8'hFF, 1'b0);
    chk_status("overflow");
    for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    chk_status("fill_drain");

    // Continuous push with ready=1: pointers wrap, count holds at 1.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 64'h8000 + 64'(i) * 64'h8, 64'hA000 + 64'(i), 8'(i + 1), 1'b1);
      chk("stream_count", {61'd0, count}, 64'd1);
    end
    step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    chk_status("stream_end");
    chk("stream_all_out", 64'(exp_q.size()), 64'd0);

    // Youngest match is partial: load must stall in both builds.
    step(1'b1, 64'h2000, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0);
    step(1'b1, 64'h2004, 64'hBBBB_BBBB_BBBB_BBBB, 8'h0F, 1'b0);
    ld_addr = 64'h2000;
    chk_ld("partial", 1'b0, 64'd0, 1'b1);
    step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    chk_ld("partial_drained", 1'b0, 64'd0, 1'b0);
    chk_status("partial_end");

    // Full-doubleword match, then a younger full match to the same doubleword.
    step(1'b1, 64'h3008, 64'h11, 8'hFF, 1'b0);
    ld_addr = 64'h300C;
`ifdef STB_LOAD_FWD_EN
    chk_ld("fwd_single", 1'b1, 64'h11, 1'b0);
`else
    chk_ld("fwd_single", 1'b0, 64'd0, 1'b1);
`endif
    ld_addr = 64'h3010;
    chk_ld("fwd_miss", 1'b0, 64'd0, 1'b0);
    step(1'b1, 64'h300F, 64'h22, 8'hFF, 1'b0);
    step(1'b1, 64'h3048, 64'h33, 8'h00, 1'b0);
    ld_addr = 64'h3008;
`ifdef STB_LOAD_FWD_EN
    chk_ld("fwd_youngest", 1'b1, 64'h22, 1'b0);
`else
    chk_ld("fwd_youngest", 1'b0, 64'd0, 1'b1);
`endif
    chk_status("fwd_pending");
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    chk_status("fwd_drained");
    chk_ld("fwd_after", 1'b0, 64'd0, 1'b0);

    // Asynchronous reset mid-drain with three entries pending.
    for (int i = 0; i < 3; i++) step(1'b1, 64'h4000 + 64'(i) * 64'h8, 64'(i), 8'hFF, 1'b0);
    chk_status("pre_reset");
    rst_n = 1'b0;
    #1;
    mcount = 0;
    movf   = 1'b0;
    exp_q.delete();
    chk_status("async_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1'b1, 64'h5000, 64'h55, 8'hFF, 1'b0);
    step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1);
    chk_status("post_reset");
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
